// File: rtl/multi_core_pmu.sv
// Programmable performance-monitoring unit: per-counter event and core-mask selection,
// wrap or saturate counting, sticky overflow interrupt and windowed snapshots.
module multi_core_pmu #(
    parameter int NUM_CORES    = 4,
    parameter int NUM_COUNTERS = 8,
    parameter int CNT_WIDTH    = 32,
    parameter int WIN_WIDTH    = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_CORES-1:0] core_active_i,
    input  logic [NUM_CORES-1:0] instruction_retired_i,
    input  logic [NUM_CORES-1:0] pipeline_stall_i,
    input  logic [NUM_CORES-1:0] branch_mispredicted_i,
    input  logic [NUM_CORES-1:0] l1_icache_miss_i,
    input  logic [NUM_CORES-1:0] l1_dcache_miss_i,
    input  logic                 cfg_we_i,
    input  logic                 cfg_re_i,
    input  logic [7:0]           cfg_addr_i,
    input  logic [31:0]          cfg_wdata_i,
    output logic [31:0]          cfg_rdata_o,
    output logic                 cfg_rvalid_o,
    output logic                 window_done_o,
    output logic                 irq_o
);
    localparam int SUM_W = CNT_WIDTH + 1;
    localparam int INC_W = $clog2(NUM_CORES + 1);

    logic                    global_en, auto_clear, freeze_on_ovf;
    logic [WIN_WIDTH-1:0]    winlen, timer;
    logic [NUM_COUNTERS-1:0] status, irqen, ctrl_en, ctrl_sat;
    logic [2:0]              ctrl_evsel [NUM_COUNTERS];
    logic [NUM_CORES-1:0]    ctrl_mask  [NUM_COUNTERS];
    logic [CNT_WIDTH-1:0]    live       [NUM_COUNTERS];
    logic [CNT_WIDTH-1:0]    snap       [NUM_COUNTERS];

    logic [NUM_CORES-1:0]    events     [8];
    logic [CNT_WIDTH-1:0]    post_inc   [NUM_COUNTERS];
    logic [CNT_WIDTH-1:0]    live_wdata;
    logic [NUM_COUNTERS-1:0] ovf_set, ctrl_wr, live_wr;
    logic [INC_W-1:0]        inc;
    logic [SUM_W-1:0]        sum;
    logic                    frozen, win_run, terminal;
    logic                    wr_gctrl, wr_winlen, wr_status, wr_irqen;
    logic [31:0]             rd_data;

    // Register port: a write commits on the clock edge where cfg_we_i is high. A cfg_re_i
    // cycle returns the pre-write register state one cycle later with cfg_rvalid_o high for
    // exactly that one cycle; cfg_rdata_o holds between reads. There is no back-pressure.
    always_comb begin
        wr_gctrl   = cfg_we_i && (cfg_addr_i == 8'h00);
        wr_winlen  = cfg_we_i && (cfg_addr_i == 8'h01);
        wr_status  = cfg_we_i && (cfg_addr_i == 8'h02);
        wr_irqen   = cfg_we_i && (cfg_addr_i == 8'h03);
        live_wdata = cfg_wdata_i[CNT_WIDTH-1:0];
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            ctrl_wr[i] = cfg_we_i && (cfg_addr_i == 8'(16 + i));
            live_wr[i] = cfg_we_i && (cfg_addr_i == 8'(32 + i));
        end
    end

    always_comb begin
        events[0] = core_active_i;
        events[1] = instruction_retired_i;
        events[2] = pipeline_stall_i;
        events[3] = branch_mispredicted_i;
        events[4] = l1_icache_miss_i;
        events[5] = l1_dcache_miss_i;
        events[6] = '0;
        events[7] = '0;
    end

    // The extra sum bit is the carry-out in wrap mode and the clamp flag in saturate mode.
    always_comb begin
        frozen   = freeze_on_ovf && (|status);
        win_run  = global_en && (winlen != '0);
        terminal = win_run && (timer == winlen - WIN_WIDTH'(1));
        ovf_set  = '0;
        inc      = '0;
        sum      = '0;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            inc = '0;
            for (int c = 0; c < NUM_CORES; c++) begin
                inc = inc + INC_W'(events[ctrl_evsel[i]][c] & ctrl_mask[i][c]);
            end
            if (global_en && ctrl_en[i] && !frozen) begin
                sum = {1'b0, live[i]} + SUM_W'(inc);
            end else begin
                sum = {1'b0, live[i]};
            end
            post_inc[i] = (ctrl_sat[i] && sum[CNT_WIDTH]) ? '1 : sum[CNT_WIDTH-1:0];
            ovf_set[i]  = sum[CNT_WIDTH] && !live_wr[i];
        end
    end

    always_comb begin
        rd_data = '0;
        case (cfg_addr_i)
            8'h00:   rd_data[2:0] = {freeze_on_ovf, auto_clear, global_en};
            8'h01:   rd_data = 32'(winlen);
            8'h02:   rd_data = 32'(status);
            8'h03:   rd_data = 32'(irqen);
            default: ;
        endcase
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (cfg_addr_i == 8'(16 + i)) begin
                rd_data[0]               = ctrl_en[i];
                rd_data[1]               = ctrl_sat[i];
                rd_data[4:2]             = ctrl_evsel[i];
                rd_data[8 +: NUM_CORES]  = ctrl_mask[i];
            end
            if (cfg_addr_i == 8'(32 + i)) rd_data = 32'(live[i]);
            if (cfg_addr_i == 8'(48 + i)) rd_data = 32'(snap[i]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            global_en     <= 1'b0;
            auto_clear    <= 1'b0;
            freeze_on_ovf <= 1'b0;
            winlen        <= '0;
            timer         <= '0;
            status        <= '0;
            irqen         <= '0;
            ctrl_en       <= '0;
            ctrl_sat      <= '0;
            cfg_rdata_o   <= '0;
            cfg_rvalid_o  <= 1'b0;
            window_done_o <= 1'b0;
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                ctrl_evsel[i] <= '0;
                ctrl_mask[i]  <= '0;
                live[i]       <= '0;
                snap[i]       <= '0;
            end
        end else begin
            cfg_rvalid_o  <= cfg_re_i;
            window_done_o <= terminal;
            if (cfg_re_i)  cfg_rdata_o <= rd_data;
            if (wr_gctrl)  {freeze_on_ovf, auto_clear, global_en} <= cfg_wdata_i[2:0];
            if (wr_winlen) winlen <= cfg_wdata_i[WIN_WIDTH-1:0];
            if (wr_irqen)  irqen <= cfg_wdata_i[NUM_COUNTERS-1:0];
            // A fresh overflow beats a same-cycle write-1-to-clear.
            status <= (status & ~({NUM_COUNTERS{wr_status}} & cfg_wdata_i[NUM_COUNTERS-1:0]))
                      | ovf_set;
            if (wr_winlen) begin
                timer <= '0;
            end else if (win_run) begin
                timer <= terminal ? '0 : timer + WIN_WIDTH'(1);
            end
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                if (ctrl_wr[i]) begin
                    ctrl_en[i]    <= cfg_wdata_i[0];
                    ctrl_sat[i]   <= cfg_wdata_i[1];
                    ctrl_evsel[i] <= cfg_wdata_i[4:2];
                    ctrl_mask[i]  <= cfg_wdata_i[8 +: NUM_CORES];
                end
                if (live_wr[i]) begin
                    live[i] <= live_wdata;
                end else if (terminal && auto_clear) begin
                    live[i] <= '0;
                end else begin
                    live[i] <= post_inc[i];
                end
                if (terminal) snap[i] <= live_wr[i] ? live_wdata : post_inc[i];
            end
        end
    end

    assign irq_o = |(status & irqen);

endmodule

// File: tb/tb_multi_core_pmu.sv
// Bench for multi_core_pmu: register-map table, directed corner sequences and a
// randomized phase scored against a cycle-level integer model of the unit.
module tb_multi_core_pmu;
    localparam int NCORE = 4;
    localparam int NCNT  = 8;
    localparam int CW    = 16;
    localparam int WW    = 16;
    localparam int unsigned CMAX = (1 << CW) - 1;
    localparam int unsigned WMAX = (1 << WW) - 1;
    localparam logic [31:0] CTRL_BITS = 32'h0000_0F1F;
    localparam logic [31:0] CNT_BITS  = 32'h0000_00FF;

    logic             clk_i, rst_ni;
    logic [NCORE-1:0] core_active_i, instruction_retired_i, pipeline_stall_i;
    logic [NCORE-1:0] branch_mispredicted_i, l1_icache_miss_i, l1_dcache_miss_i;
    logic             cfg_we_i, cfg_re_i;
    logic [7:0]       cfg_addr_i;
    logic [31:0]      cfg_wdata_i, cfg_rdata_o;
    logic             cfg_rvalid_o, window_done_o, irq_o;

    int n_checks = 0;
    int n_errors = 0;

    multi_core_pmu #(
        .NUM_CORES(NCORE), .NUM_COUNTERS(NCNT), .CNT_WIDTH(CW), .WIN_WIDTH(WW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .core_active_i(core_active_i), .instruction_retired_i(instruction_retired_i),
        .pipeline_stall_i(pipeline_stall_i), .branch_mispredicted_i(branch_mispredicted_i),
        .l1_icache_miss_i(l1_icache_miss_i), .l1_dcache_miss_i(l1_dcache_miss_i),
        .cfg_we_i(cfg_we_i), .cfg_re_i(cfg_re_i), .cfg_addr_i(cfg_addr_i),
        .cfg_wdata_i(cfg_wdata_i), .cfg_rdata_o(cfg_rdata_o), .cfg_rvalid_o(cfg_rvalid_o),
        .window_done_o(window_done_o), .irq_o(irq_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_gctrl, m_winlen, m_timer, m_status, m_irqen, m_rdata;
    logic [31:0] m_ctrl [NCNT];
    int unsigned m_live [NCNT];
    int unsigned m_snap [NCNT];
    logic        m_done, m_rvalid;
    logic [31:0] exp_q[$];

    function automatic logic [NCORE-1:0] ev_of(input int sel);
        case (sel)
            0: return core_active_i;
            1: return instruction_retired_i;
            2: return pipeline_stall_i;
            3: return branch_mispredicted_i;
            4: return l1_icache_miss_i;
            5: return l1_dcache_miss_i;
            default: return '0;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a);
        int i;
        i = int'(a[3:0]);
        if (a == 8'h00) return m_gctrl;
        if (a == 8'h01) return m_winlen;
        if (a == 8'h02) return m_status;
        if (a == 8'h03) return m_irqen;
        if (i < NCNT) begin
            if (a[7:4] == 4'h1) return m_ctrl[i];
            if (a[7:4] == 4'h2) return m_live[i];
            if (a[7:4] == 4'h3) return m_snap[i];
        end
        return 32'h0;
    endfunction

    task automatic m_reset();
        m_gctrl = 0; m_winlen = 0; m_timer = 0; m_status = 0; m_irqen = 0; m_rdata = 0;
        m_done = 0; m_rvalid = 0;
        exp_q.delete();
        for (int i = 0; i < NCNT; i++) begin
            m_ctrl[i] = 0; m_live[i] = 0; m_snap[i] = 0;
        end
    endtask

    task automatic m_step();
        logic [31:0] set_bits, w1c;
        int unsigned nxt_live [NCNT];
        bit gen, ac, frz, running, term, wr;
        int a;
        gen     = m_gctrl[0];
        ac      = m_gctrl[1];
        frz     = m_gctrl[2] && (m_status != 0);
        running = gen && (m_winlen != 0);
        term    = running && (m_timer == m_winlen - 1);
        wr      = cfg_we_i;
        a       = int'(cfg_addr_i);
        set_bits = 0;
        m_rvalid = cfg_re_i;
        if (cfg_re_i) begin
            m_rdata = m_read(cfg_addr_i);
            exp_q.push_back(m_rdata);
        end
        for (int i = 0; i < NCNT; i++) begin
            int unsigned inc, total, kept;
            bit act, lw;
            inc   = $countones(ev_of(int'(m_ctrl[i][4:2])) & m_ctrl[i][11:8]);
            act   = gen && m_ctrl[i][0] && !frz;
            lw    = wr && (a == 32 + i);
            total = m_live[i] + (act ? inc : 0);
            kept  = total;
            if (total > CMAX) begin
                if (!lw) set_bits[i] = 1'b1;
                kept = m_ctrl[i][1] ? CMAX : total - (CMAX + 1);
            end
            if (lw) nxt_live[i] = cfg_wdata_i & CMAX;
            else if (term && ac) nxt_live[i] = 0;
            else nxt_live[i] = kept;
            if (term) m_snap[i] = lw ? (cfg_wdata_i & CMAX) : kept;
        end
        for (int i = 0; i < NCNT; i++) m_live[i] = nxt_live[i];
        w1c = (wr && a == 2) ? (cfg_wdata_i & CNT_BITS) : 32'h0;
        m_status = (m_status & ~w1c) | set_bits;
        if (wr && a == 1) m_timer = 0;
        else if (running) m_timer = term ? 0 : m_timer + 1;
        m_done = term;
        if (wr) begin
            if (a == 0) m_gctrl = cfg_wdata_i & 32'h7;
            if (a == 1) m_winlen = cfg_wdata_i & WMAX;
            if (a == 3) m_irqen = cfg_wdata_i & CNT_BITS;
            if (a >= 16 && a < 16 + NCNT) m_ctrl[a - 16] = cfg_wdata_i & CTRL_BITS;
        end
    endtask

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) m_reset();
        else m_step();
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk_i) begin
        if (rst_ni) begin
            check("rvalid", {31'b0, cfg_rvalid_o}, {31'b0, m_rvalid});
            if (m_rvalid) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL rdata: got 0x%08h but no read was expected", cfg_rdata_o);
                end else begin
                    check("rdata", cfg_rdata_o, exp_q.pop_front());
                end
            end else begin
                check("rdata_hold", cfg_rdata_o, m_rdata);
            end
            check("window_done", {31'b0, window_done_o}, {31'b0, m_done});
            check("irq", {31'b0, irq_o}, {31'b0, ((m_status & m_irqen) != 0)});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        core_active_i = '0; instruction_retired_i = '0; pipeline_stall_i = '0;
        branch_mispredicted_i = '0; l1_icache_miss_i = '0; l1_dcache_miss_i = '0;
        cfg_we_i = 0; cfg_re_i = 0; cfg_addr_i = '0; cfg_wdata_i = '0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 0;
        idle_inputs();
        repeat (2) @(negedge clk_i);
        rst_ni = 1;
    endtask

    task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
        cfg_we_i = 1; cfg_addr_i = a; cfg_wdata_i = d;
        @(negedge clk_i);
        cfg_we_i = 0;
    endtask

    task automatic cfg_read(input logic [7:0] a, output logic [31:0] d);
        cfg_re_i = 1; cfg_addr_i = a;
        @(negedge clk_i);
        cfg_re_i = 0;
        d = cfg_rdata_o;
    endtask

    function automatic logic [7:0] rand_addr();
        case ($urandom_range(0, 8))
            0: return 8'h00;
            1: return 8'h01;
            2: return 8'h02;
            3: return 8'h03;
            4: return 8'(16 + $urandom_range(0, 9));
            5, 6: return 8'(32 + $urandom_range(0, 9));
            7: return 8'(48 + $urandom_range(0, 9));
            default: return 8'($urandom);
        endcase
    endfunction

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rexp;
    } vec_t;

    vec_t        vecs [14];
    logic [31:0] d;
    int          first_done;

    initial begin
        rst_ni = 0;
        idle_inputs();
        do_reset();

        // Reset state
        check("reset_irq", {31'b0, irq_o}, 32'h0);
        cfg_read(8'h00, d); check("reset_gctrl", d, 32'h0);
        cfg_read(8'h02, d); check("reset_status", d, 32'h0);
        cfg_read(8'h23, d); check("reset_live3", d, 32'h0);

        // Register map write/readback table (global_en stays low)
        vecs[0]  = '{8'h00, 32'hFFFF_FFFE, 32'h0000_0006};
        vecs[1]  = '{8'h01, 32'hABCD_1234, 32'h0000_1234};
        vecs[2]  = '{8'h03, 32'hFFFF_FFFF, 32'h0000_00FF};
        vecs[3]  = '{8'h13, 32'hFFFF_FFFF, 32'h0000_0F1F};
        vecs[4]  = '{8'h17, 32'h0000_1234, 32'h0000_0214};
        vecs[5]  = '{8'h25, 32'h0001_2345, 32'h0000_2345};
        vecs[6]  = '{8'h35, 32'h0000_0777, 32'h0000_0000};
        vecs[7]  = '{8'h02, 32'h0000_00FF, 32'h0000_0000};
        vecs[8]  = '{8'h05, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[9]  = '{8'h18, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[10] = '{8'h28, 32'h0000_1111, 32'h0000_0000};
        vecs[11] = '{8'h40, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[12] = '{8'hFF, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[13] = '{8'h01, 32'h0000_0000, 32'h0000_0000};
        for (int i = 0; i < 14; i++) begin
            cfg_write(vecs[i].addr, vecs[i].wdata);
            cfg_read(vecs[i].addr, d);
            check($sformatf("vec%0d_addr%02h", i, vecs[i].addr), d, vecs[i].rexp);
        end

        // Basic counting: 3 retiring cores for 10 cycles
        do_reset();
        cfg_write(8'h10, 32'h0000_0F05);
        cfg_write(8'h00, 32'h1);
        instruction_retired_i = 4'b1011;
        repeat (10) @(negedge clk_i);
        instruction_retired_i = 4'b0000;
        cfg_read(8'h20, d); check("t1_live0", d, 32'd30);

        // Saturation, irq, W1C and re-set while at max
        cfg_write(8'h11, 32'h0000_0F07);
        cfg_write(8'h21, 32'h0000_FFFE);
        cfg_write(8'h03, 32'h0000_0002);
        instruction_retired_i = 4'hF;
        @(negedge clk_i);
        instruction_retired_i = 4'h0;
        check("t2_irq_set", {31'b0, irq_o}, 32'h1);
        cfg_read(8'h21, d); check("t2_live1_sat", d, 32'h0000_FFFF);
        cfg_read(8'h02, d); check("t2_status", d, 32'h2);
        cfg_write(8'h02, 32'h2);
        check("t2_irq_clr", {31'b0, irq_o}, 32'h0);
        cfg_read(8'h02, d); check("t2_status_clr", d, 32'h0);
        instruction_retired_i = 4'hF;
        @(negedge clk_i);
        instruction_retired_i = 4'h0;
        cfg_read(8'h02, d); check("t2_status_reset", d, 32'h2);

        // Overflow beats same-cycle W1C; write beats same-cycle increment
        instruction_retired_i = 4'hF;
        cfg_write(8'h02, 32'h2);
        instruction_retired_i = 4'b0111;
        cfg_write(8'h20, 32'd100);
        instruction_retired_i = 4'h0;
        cfg_read(8'h02, d); check("t5_status_setwins", d, 32'h2);
        cfg_read(8'h20, d); check("t5_live0_write", d, 32'd100);

        // Wrap with freeze_on_ovf
        do_reset();
        cfg_write(8'h10, 32'h0000_0F05);
        cfg_write(8'h12, 32'h0000_0305);
        cfg_write(8'h22, 32'h0000_FFFF);
        cfg_write(8'h00, 32'h5);
        instruction_retired_i = 4'hF;
        repeat (4) @(negedge clk_i);
        instruction_retired_i = 4'h0;
        cfg_read(8'h22, d); check("t3_live2_wrap", d, 32'h1);
        cfg_read(8'h02, d); check("t3_status", d, 32'h4);
        cfg_read(8'h20, d); check("t3_live0_frozen", d, 32'h4);

        // Windowing with auto_clear
        do_reset();
        cfg_write(8'h10, 32'h0000_0101);
        cfg_write(8'h01, 32'd5);
        core_active_i = 4'b0001;
        cfg_write(8'h00, 32'h3);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk_i);
            check($sformatf("t4_done_k%0d", k), {31'b0, window_done_o}, {31'b0, (k % 5 == 0)});
        end
        cfg_read(8'h20, d);
        n_checks++;
        if (d > 32'd4) begin
            n_errors++;
            $display("FAIL t4_live_bound: got 0x%08h expected at most 0x00000004", d);
        end
        cfg_read(8'h30, d); check("t4_snap0", d, 32'd5);

        // Asynchronous reset mid-window
        #2 rst_ni = 0;
        #1;
        check("t6_rdata_rst", cfg_rdata_o, 32'h0);
        check("t6_rvalid_rst", {31'b0, cfg_rvalid_o}, 32'h0);
        check("t6_done_rst", {31'b0, window_done_o}, 32'h0);
        check("t6_irq_rst", {31'b0, irq_o}, 32'h0);
        idle_inputs();
        @(negedge clk_i);
        rst_ni = 1;
        cfg_read(8'h30, d); check("t6_snap_cleared", d, 32'h0);
        cfg_write(8'h10, 32'h0000_0101);
        cfg_write(8'h01, 32'd5);
        core_active_i = 4'b0001;
        cfg_write(8'h00, 32'h3);
        first_done = 0;
        for (int k = 1; k <= 20 && first_done == 0; k++) begin
            @(negedge clk_i);
            if (window_done_o) first_done = k;
        end
        check("t6_first_window", 32'(first_done), 32'd5);

        // Randomized phase scored by the model
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            core_active_i         = 4'($urandom);
            instruction_retired_i = 4'($urandom);
            pipeline_stall_i      = 4'($urandom);
            branch_mispredicted_i = 4'($urandom);
            l1_icache_miss_i      = 4'($urandom);
            l1_dcache_miss_i      = 4'($urandom);
            cfg_we_i   = ($urandom_range(0, 3) == 0);
            cfg_re_i   = ($urandom_range(0, 2) == 0);
            cfg_addr_i = rand_addr();
            if (cfg_addr_i == 8'h01) cfg_wdata_i = 32'($urandom_range(0, 6));
            else if (cfg_addr_i == 8'h00) cfg_wdata_i = 32'($urandom_range(0, 7) | 1);
            else if (cfg_addr_i[7:4] == 4'h2 && $urandom_range(0, 1) == 0)
                cfg_wdata_i = 32'(16'hFFF0 + $urandom_range(0, 15));
            else cfg_wdata_i = $urandom;
            @(negedge clk_i);
        end
        idle_inputs();
        repeat (3) @(negedge clk_i);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
